// File: rtl/microwave_controller.sv
// Microwave oven controller: keypad time entry, 1 s countdown, door interlock.
// Define MICROWAVE_BEEP_EN to sound the buzzer for BEEP_SECS seconds in DONE.
module microwave_controller #(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned BEEP_SECS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       door_open,
    input  logic       key_start,
    input  logic       key_stop,
    input  logic       key_add_min,
    input  logic       key_add_10s,
    output logic       magnetron_on,
    output logic       lamp_on,
    output logic       buzzer,
    output logic [6:0] time_min,
    output logic [5:0] time_sec,
    output logic [2:0] state,
    output logic       done
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        state_q, state_d;
    logic [6:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;

    logic          k_stop, k_start, k_min, k_10s, any_key, tick, beep_end;
    logic [12:0]   cur_t, dec_t, cook_t, cur_add, cook_add;

    // Add keys saturate at 99:59 and never lower the time.
    function automatic logic [12:0] add_time(input logic [12:0] t,
                                             input logic am,
                                             input logic a10);
        logic [6:0] m;
        logic [5:0] s;
        {m, s} = t;
        if (am) begin
            if (m < 7'd99) m = m + 7'd1;
        end else if (a10) begin
            if (s < 6'd50) begin
                s = s + 6'd10;
            end else if (m < 7'd99) begin
                m = m + 7'd1;
                s = s - 6'd50;
            end else begin
                s = 6'd59;
            end
        end
        return {m, s};
    endfunction

    assign k_stop  = key_stop;
    assign k_start = key_start & ~key_stop;
    assign k_min   = key_add_min & ~key_start & ~key_stop;
    assign k_10s   = key_add_10s & ~key_add_min & ~key_start & ~key_stop;
    assign any_key = key_start | key_stop | key_add_min | key_add_10s;
    assign tick    = (presc_q == PRESC_LAST);

    assign cur_t    = {min_q, sec_q};
    assign dec_t    = (sec_q != 6'd0) ? {min_q, sec_q - 6'd1}
                                      : {min_q - 7'd1, 6'd59};
    assign cook_t   = tick ? dec_t : cur_t;
    assign cur_add  = add_time(cur_t, k_min, k_10s);
    assign cook_add = add_time(cook_t, k_min, k_10s);

`ifdef MICROWAVE_BEEP_EN
    localparam int unsigned BEEP_CYC = BEEP_SECS * TICK_DIV;
    localparam int unsigned BW = $clog2(BEEP_CYC);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYC - 1);

    logic [BW-1:0] beep_q, beep_d;

    always_comb begin
        beep_d = '0;
        if (state_q == S_DONE) beep_d = beep_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) beep_q <= '0;
        else     beep_q <= beep_d;
    end

    assign beep_end = (beep_q == BEEP_LAST);
    assign buzzer   = (state_q == S_DONE);
`else
    logic unused_beep;
    assign unused_beep = ^BEEP_SECS;
    assign beep_end    = 1'b1;
    assign buzzer      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        presc_d = '0;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                min_d = '0;
                sec_d = '0;
                if (k_start) begin
                    if (!door_open) begin
                        state_d = S_COOK;
                        sec_d   = 6'd30;
                    end
                end else if (k_min || k_10s) begin
                    state_d        = S_SET;
                    {min_d, sec_d} = cur_add;
                end
            end
            S_SET, S_PAUSE: begin
                if (k_stop) begin
                    state_d = S_IDLE;
                    min_d   = '0;
                    sec_d   = '0;
                end else if (k_start) begin
                    if (!door_open) state_d = S_COOK;
                end else begin
                    {min_d, sec_d} = cur_add;
                end
            end
            S_COOK: begin
                if (k_stop || door_open) begin
                    state_d = S_PAUSE;
                end else begin
                    presc_d        = tick ? '0 : presc_q + 1'b1;
                    {min_d, sec_d} = cook_add;
                    // A coinciding add key keeps the time above zero.
                    if (cook_add == 13'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                min_d = '0;
                sec_d = '0;
                if (any_key || door_open || beep_end) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                min_d   = '0;
                sec_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            min_q   <= '0;
            sec_q   <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    assign state        = state_q;
    assign time_min     = min_q;
    assign time_sec     = sec_q;
    assign done         = done_q;
    assign magnetron_on = (state_q == S_COOK) & ~door_open;
    assign lamp_on      = door_open | (state_q == S_COOK);

endmodule

// File: tb/tb_microwave_controller.sv
// Self-checking bench for microwave_controller (TICK_DIV=10, BEEP_SECS=3).
// Reference model keeps remaining time as total seconds.
module tb_microwave_controller;
    localparam int TD   = 10;
    localparam int BS   = 3;
    localparam int MAXT = 99 * 60 + 59;
    localparam int M_IDLE = 0, M_SET = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       door_open = 1'b0;
    logic       key_start = 1'b0;
    logic       key_stop = 1'b0;
    logic       key_add_min = 1'b0;
    logic       key_add_10s = 1'b0;
    logic       magnetron_on, lamp_on, buzzer, done;
    logic [6:0] time_min;
    logic [5:0] time_sec;
    logic [2:0] state;

    microwave_controller #(.TICK_DIV(TD), .BEEP_SECS(BS)) dut (
        .clk          (clk),
        .rst          (rst),
        .door_open    (door_open),
        .key_start    (key_start),
        .key_stop     (key_stop),
        .key_add_min  (key_add_min),
        .key_add_10s  (key_add_10s),
        .magnetron_on (magnetron_on),
        .lamp_on      (lamp_on),
        .buzzer       (buzzer),
        .time_min     (time_min),
        .time_sec     (time_sec),
        .state        (state),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MICROWAVE_BEEP_EN
    localparam bit BEEP = 1'b1;
`else
    localparam bit BEEP = 1'b0;
`endif

    // model state
    int m_state, m_t, m_ph, m_beep;
    bit m_done;

    function automatic int bump(input int t, input bit am, input bit a10);
        if (am)  return (t / 60 < 99) ? t + 60 : t;
        if (a10) return (t + 10 > MAXT) ? MAXT : t + 10;
        return t;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_t     = 0;
        m_ph    = 0;
        m_beep  = 0;
        m_done  = 1'b0;
    endtask

    task automatic model_step(input bit ks, input bit kp, input bit km,
                              input bit k10, input bit door);
        bit st, am, a10;
        int nt;
        st  = ks && !kp;
        am  = km && !ks && !kp;
        a10 = k10 && !km && !ks && !kp;
        m_done = 1'b0;
        case (m_state)
            M_IDLE: begin
                if (st) begin
                    if (!door) begin
                        m_state = M_COOK;
                        m_t     = 30;
                        m_ph    = 0;
                    end
                end else if (am || a10) begin
                    m_state = M_SET;
                    m_t     = bump(m_t, am, a10);
                end
            end
            M_SET, M_PAUSE: begin
                if (kp) begin
                    m_state = M_IDLE;
                    m_t     = 0;
                end else if (st) begin
                    if (!door) begin
                        m_state = M_COOK;
                        m_ph    = 0;
                    end
                end else begin
                    m_t = bump(m_t, am, a10);
                end
            end
            M_COOK: begin
                if (kp || door) begin
                    m_state = M_PAUSE;
                end else begin
                    nt = m_t;
                    if (m_ph == TD - 1) begin
                        nt   = nt - 1;
                        m_ph = 0;
                    end else begin
                        m_ph = m_ph + 1;
                    end
                    nt  = bump(nt, am, a10);
                    m_t = nt;
                    if (nt == 0) begin
                        m_state = M_DONE;
                        m_done  = 1'b1;
                        m_beep  = 0;
                    end
                end
            end
            default: begin
                m_t = 0;
                if (BEEP) begin
                    m_beep = m_beep + 1;
                    if (ks || kp || km || k10 || door || m_beep == BS * TD)
                        m_state = M_IDLE;
                end else begin
                    m_state = M_IDLE;
                end
            end
        endcase
    endtask

    task automatic cyc(input bit ks, input bit kp, input bit km, input bit k10);
        key_start   = ks;
        key_stop    = kp;
        key_add_min = km;
        key_add_10s = k10;
        @(posedge clk);
        #1;
        model_step(ks, kp, km, k10, door_open);
        key_start   = 1'b0;
        key_stop    = 1'b0;
        key_add_min = 1'b0;
        key_add_10s = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        door_open = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (state !== 3'd0 || time_min !== 7'd0 || time_sec !== 6'd0 ||
            magnetron_on !== 1'b0 || buzzer !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: st=%0d %0d:%0d mag=%b buz=%b done=%b, required all 0",
                     state, time_min, time_sec, magnetron_on, buzzer, done);
        end
        n_checks++;
        if (lamp_on !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_lamp_door_open: lamp=%b required 1", lamp_on);
        end
        door_open = 1'b0;
        #1;
        n_checks++;
        if (lamp_on !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_lamp_door_closed: lamp=%b required 0", lamp_on);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_cook_to_done();
        int cnt, dn, bz, dp, bad;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        n_checks++;
        if (state !== 3'd1 || time_min !== 7'd0 || time_sec !== 6'd20) begin
            n_fail++;
            $display("FAIL set_20s: st=%0d %0d:%0d required 1 0:20", state, time_min, time_sec);
        end
        cyc(1, 0, 0, 0);
        n_checks++;
        if (state !== 3'd2 || time_sec !== 6'd20 || magnetron_on !== 1'b1 || lamp_on !== 1'b1) begin
            n_fail++;
            $display("FAIL cook_start: st=%0d sec=%0d mag=%b lamp=%b required 2 20 1 1",
                     state, time_sec, magnetron_on, lamp_on);
        end
        cnt = 0;
        bad = 0;
        for (int i = 1; i <= 250 && cnt == 0; i++) begin
            cyc(0, 0, 0, 0);
            if (state !== 3'(m_state) || time_sec !== 6'(m_t % 60) || time_min !== 7'(m_t / 60))
                bad++;
            if (done === 1'b1) cnt = i;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL countdown_track: %0d cycles off model, required 0", bad);
        end
        n_checks++;
        if (cnt != 200 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL done_latency: done after %0d cycles st=%0d, required 200 st=4", cnt, state);
        end
        dn = 0;
        bz = 0;
        dp = 0;
        for (int i = 0; i < 100 && state === 3'd4; i++) begin
            dn++;
            if (buzzer === 1'b1) bz++;
            if (done === 1'b1) dp++;
            cyc(0, 0, 0, 0);
        end
        n_checks++;
        if (dn != (BEEP ? BS * TD : 1) || bz != (BEEP ? BS * TD : 0) || dp != 1 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL done_phase: done_cycles=%0d buzz=%0d pulses=%0d st=%0d, required %0d %0d 1 0",
                     dn, bz, dp, state, BEEP ? BS * TD : 1, BEEP ? BS * TD : 0);
        end
    endtask

    task automatic test_quick_pause();
        cyc(1, 0, 0, 0);
        n_checks++;
        if (state !== 3'd2 || time_min !== 7'd0 || time_sec !== 6'd30 || magnetron_on !== 1'b1) begin
            n_fail++;
            $display("FAIL quick_start: st=%0d %0d:%0d mag=%b required 2 0:30 1",
                     state, time_min, time_sec, magnetron_on);
        end
        repeat (5 * TD) cyc(0, 0, 0, 0);
        n_checks++;
        if (time_sec !== 6'd25 || m_t != 25) begin
            n_fail++;
            $display("FAIL cook_to_25: sec=%0d required 25", time_sec);
        end
        door_open = 1'b1;
        #1;
        n_checks++;
        if (magnetron_on !== 1'b0 || state !== 3'd2 || lamp_on !== 1'b1) begin
            n_fail++;
            $display("FAIL door_interlock: mag=%b st=%0d lamp=%b required 0 2 1",
                     magnetron_on, state, lamp_on);
        end
        cyc(0, 0, 0, 0);
        n_checks++;
        if (state !== 3'd3 || time_sec !== 6'd25) begin
            n_fail++;
            $display("FAIL door_pause: st=%0d sec=%0d required 3 25", state, time_sec);
        end
        cyc(1, 0, 0, 0);
        n_checks++;
        if (state !== 3'd3) begin
            n_fail++;
            $display("FAIL start_door_open: st=%0d required 3", state);
        end
        door_open = 1'b0;
        cyc(1, 0, 0, 0);
        repeat (TD) cyc(0, 0, 0, 0);
        n_checks++;
        if (state !== 3'd2 || time_sec !== 6'd24 || magnetron_on !== 1'b1) begin
            n_fail++;
            $display("FAIL resume: st=%0d sec=%0d mag=%b required 2 24 1",
                     state, time_sec, magnetron_on);
        end
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        n_checks++;
        if (state !== 3'd0 || time_sec !== 6'd0) begin
            n_fail++;
            $display("FAIL pause_stop: st=%0d sec=%0d required 0 0", state, time_sec);
        end
    endtask

    task automatic test_saturation();
        repeat (100) cyc(0, 0, 1, 0);
        n_checks++;
        if (state !== 3'd1 || time_min !== 7'd99 || time_sec !== 6'd0) begin
            n_fail++;
            $display("FAIL min_sat: st=%0d %0d:%0d required 1 99:0", state, time_min, time_sec);
        end
        repeat (7) cyc(0, 0, 0, 1);
        n_checks++;
        if (time_min !== 7'd99 || time_sec !== 6'd59) begin
            n_fail++;
            $display("FAIL sec_sat: %0d:%0d required 99:59", time_min, time_sec);
        end
        cyc(0, 1, 0, 0);
        n_checks++;
        if (state !== 3'd0 || time_min !== 7'd0 || time_sec !== 6'd0) begin
            n_fail++;
            $display("FAIL set_stop: st=%0d %0d:%0d required 0 0:0", state, time_min, time_sec);
        end
    endtask

    task automatic test_priority();
        door_open = 1'b1;
        cyc(1, 0, 1, 0);
        door_open = 1'b0;
        n_checks++;
        if (state !== 3'd0 || time_min !== 7'd0) begin
            n_fail++;
            $display("FAIL start_over_add: st=%0d min=%0d required 0 0", state, time_min);
        end
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        repeat (TD) cyc(0, 0, 0, 0);
        n_checks++;
        if (state !== 3'd2 || time_min !== 7'd0 || time_sec !== 6'd59) begin
            n_fail++;
            $display("FAIL first_tick: st=%0d %0d:%0d required 2 0:59", state, time_min, time_sec);
        end
        cyc(1, 1, 0, 0);
        n_checks++;
        if (state !== 3'd3 || time_sec !== 6'd59) begin
            n_fail++;
            $display("FAIL stop_over_start: st=%0d sec=%0d required 3 59", state, time_sec);
        end
        cyc(0, 0, 1, 1);
        n_checks++;
        if (time_min !== 7'd1 || time_sec !== 6'd59) begin
            n_fail++;
            $display("FAIL min_over_10s: %0d:%0d required 1:59", time_min, time_sec);
        end
        cyc(0, 1, 0, 0);
    endtask

    task automatic test_add_at_zero();
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        repeat (10 * TD - 1) cyc(0, 0, 0, 0);
        n_checks++;
        if (state !== 3'd2 || time_sec !== 6'd1) begin
            n_fail++;
            $display("FAIL pre_zero: st=%0d sec=%0d required 2 1", state, time_sec);
        end
        cyc(0, 0, 0, 1);
        n_checks++;
        if (state !== 3'd2 || time_min !== 7'd0 || time_sec !== 6'd10 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL add_wins: st=%0d %0d:%0d done=%b required 2 0:10 0",
                     state, time_min, time_sec, done);
        end
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
    endtask

    task automatic test_async_reset();
        cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (magnetron_on !== 1'b0 || state !== 3'd0 || time_sec !== 6'd0 || time_min !== 7'd0) begin
            n_fail++;
            $display("FAIL async_reset: mag=%b st=%0d %0d:%0d required 0 0 0:0",
                     magnetron_on, state, time_min, time_sec);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc(1, 0, 0, 0);
        n_checks++;
        if (state !== 3'd2 || time_sec !== 6'd30) begin
            n_fail++;
            $display("FAIL post_reset_start: st=%0d sec=%0d required 2 30", state, time_sec);
        end
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
    endtask

    task automatic test_random();
        bit ks, kp, km, k10, eb, em, el;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99, 0) < 2) door_open = ~door_open;
            ks  = ($urandom_range(99, 0) < 4);
            kp  = ($urandom_range(99, 0) < 1);
            km  = ($urandom_range(199, 0) < 1);
            k10 = ($urandom_range(99, 0) < 3);
            cyc(ks, kp, km, k10);
            eb = BEEP && (m_state == M_DONE);
            em = (m_state == M_COOK) && !door_open;
            el = door_open || (m_state == M_COOK);
            n_checks++;
            if (state !== 3'(m_state) || time_min !== 7'(m_t / 60) || time_sec !== 6'(m_t % 60) ||
                done !== m_done || buzzer !== eb || magnetron_on !== em || lamp_on !== el) begin
                n_fail++;
                $display("FAIL random[%0d]: got st=%0d %0d:%0d done=%b buz=%b mag=%b lamp=%b, required st=%0d %0d:%0d done=%b buz=%b mag=%b lamp=%b",
                         i, state, time_min, time_sec, done, buzzer, magnetron_on, lamp_on,
                         m_state, m_t / 60, m_t % 60, m_done, eb, em, el);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_cook_to_done();
        test_quick_pause();
        test_saturation();
        test_priority();
        test_add_at_zero();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
